dvp_camera_tx: RTL and testbench

- Transmit-side OV7670-style DVP source: drives p_clock, vsync, href and p_data[7:0] with RGB565 pixels, two bytes per pixel, high byte first.
- Serves as a sensor emulator: on the FPGA it feeds the capture path when no camera is fitted; in simulation it stimulates the capture path.
- Single clk domain; p_clock is generated as clk/2.

---
 rtl/dvp_camera_tx_if.sv | 23 ++
 rtl/dvp_camera_tx.sv | 136 +++++++++++++
 tb/tb_dvp_camera_tx.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/dvp_camera_tx_if.sv
// DVP transmit bundle: camera-side outputs, the pixel request/response pair
// towards the pixel source, and the frame enable/status signals.
interface dvp_camera_tx_if;
  logic        enable;
  logic        p_clock;
  logic        vsync;
  logic        href;
  logic [7:0]  p_data;
  logic        pix_req;
  logic [15:0] pix_data;
  logic        frame_start;
  logic [7:0]  frame_count;

  modport master (
    input  enable, pix_data,
    output p_clock, vsync, href, p_data, pix_req, frame_start, frame_count
  );

  modport slave (
    output enable, pix_data,
    input  p_clock, vsync, href, p_data, pix_req, frame_start, frame_count
  );
endinterface

// File: rtl/dvp_camera_tx.sv
// OV7670-style DVP source emitting RGB565 frames, high byte first, p_clock = clk/2.
// Define DVP_TX_PATTERN_EN to replace pix_data with an internal row/col/frame pattern.
module dvp_camera_tx #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 144,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 17,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic            clk,
  input  logic            resetn,
  dvp_camera_tx_if.master bus
);

  localparam int L    = 2*H_ACTIVE + H_BLANK;
  localparam int BW   = (L > 1) ? $clog2(L) : 1;
  localparam int VM1  = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
  localparam int VM2  = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int VMAX = (VM1 > VM2) ? VM1 : VM2;
  localparam int LW   = (VMAX > 1) ? $clog2(VMAX) : 1;

  localparam logic [BW-1:0] BYTE_LAST = BW'(L - 1);
  localparam logic [BW-1:0] HREF_END  = BW'(2*H_ACTIVE);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT
  } state_t;

  state_t         state_q, state_d;
  logic [BW-1:0]  byte_q, byte_d;
  logic [LW-1:0]  line_q, line_d;
  logic [7:0]     fcnt_q, fcnt_d;
  logic [15:0]    pix_q, pix_src;
  logic           p_clock_q, frame_start_q;
  logic           start_d, tick, hi_next, line_last;
  int             line_lim;

  // Every other clk edge (p_clock 1->0) is a tick; all frame state moves only then.
  assign tick = p_clock_q;

  always_comb begin
    line_lim = V_FRONT;
    case (state_q)
      S_VSYNC:  line_lim = V_SYNC;
      S_VBACK:  line_lim = V_BACK;
      S_ACTIVE: line_lim = V_ACTIVE;
      default:  line_lim = V_FRONT;
    endcase
  end

  assign line_last = (int'(line_q) == line_lim - 1);

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    line_d  = line_q;
    fcnt_d  = fcnt_q;
    start_d = 1'b0;
    if (state_q == S_IDLE) begin
      if (bus.enable) begin
        state_d = S_VSYNC;
        byte_d  = '0;
        line_d  = '0;
        start_d = 1'b1;
      end
    end else begin
      byte_d = byte_q + BW'(1);
      if (byte_q == BYTE_LAST) begin
        byte_d = '0;
        line_d = line_q + LW'(1);
        if (line_last) begin
          line_d = '0;
          case (state_q)
            S_VSYNC:  state_d = S_VBACK;
            S_VBACK:  state_d = S_ACTIVE;
            S_ACTIVE: state_d = S_VFRONT;
            default: begin
              fcnt_d = fcnt_q + 8'd1;
              if (bus.enable) begin
                state_d = S_VSYNC;
                start_d = 1'b1;
              end else begin
                state_d = S_IDLE;
              end
            end
          endcase
        end
      end
    end
  end

  // The position entered on the coming tick is a high byte: fetch a new pixel.
  assign hi_next = (state_d == S_ACTIVE) && !byte_d[0] && (byte_d < HREF_END);

`ifdef DVP_TX_PATTERN_EN
  logic [9:0] row_d, col_d;
  assign row_d       = 10'(line_d);
  assign col_d       = 10'(byte_d >> 1);
  assign pix_src     = {row_d[4:0], col_d[5:0], fcnt_q[4:0]};
  assign bus.pix_req = 1'b0;
`else
  assign pix_src     = bus.pix_data;
  assign bus.pix_req = tick & hi_next;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      p_clock_q     <= 1'b0;
      state_q       <= S_IDLE;
      byte_q        <= '0;
      line_q        <= '0;
      fcnt_q        <= '0;
      pix_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      p_clock_q     <= ~p_clock_q;
      frame_start_q <= tick & start_d;
      if (tick) begin
        state_q <= state_d;
        byte_q  <= byte_d;
        line_q  <= line_d;
        fcnt_q  <= fcnt_d;
        if (hi_next) pix_q <= pix_src;
      end
    end
  end

  assign bus.p_clock     = p_clock_q;
  assign bus.vsync       = (state_q == S_IDLE) || (state_q == S_VSYNC);
  assign bus.href        = (state_q == S_ACTIVE) && (byte_q < HREF_END);
  assign bus.p_data      = bus.href ? (byte_q[0] ? pix_q[7:0] : pix_q[15:8]) : 8'h00;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_count = fcnt_q;

endmodule

// File: tb/tb_dvp_camera_tx.sv
// Directed bench for dvp_camera_tx with a small frame geometry (L = 11 ticks,
// 5 lines per frame, 110 clk per frame); covers both pixel-source builds.
module tb_dvp_camera_tx;

  logic clk, resetn;
  dvp_camera_tx_if bus ();

  dvp_camera_tx #(
    .H_ACTIVE(4), .H_BLANK(3), .V_SYNC(1), .V_BACK(1), .V_ACTIVE(2), .V_FRONT(1)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int href_clk, vs_clk, href_rise, req_cnt, fs_cnt, bad_pdata, nrec;
  logic [7:0]  rec [16];
  logic [15:0] src_tbl [8] = '{16'h1234, 16'hABCD, 16'h5678, 16'h9EF0,
                               16'h0F1E, 16'h2D3C, 16'h4B5A, 16'h6978};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Samples n consecutive negedges starting with the current one.
  task automatic measure(input int n);
    logic prev;
    href_clk = 0; vs_clk = 0; href_rise = 0; req_cnt = 0;
    fs_cnt = 0; bad_pdata = 0; nrec = 0;
    prev = bus.href;
    for (int i = 0; i < n; i++) begin
      if (bus.href) href_clk++;
      if (bus.vsync) vs_clk++;
      if (bus.href && !prev) href_rise++;
      if (bus.pix_req) req_cnt++;
      if (bus.frame_start) fs_cnt++;
      if (!bus.href && bus.p_data != 8'h00) bad_pdata++;
      if (bus.href && !bus.p_clock && nrec < 16) begin
        rec[nrec] = bus.p_data;
        nrec++;
      end
      prev = bus.href;
      @(negedge clk);
    end
  endtask

  function automatic logic [15:0] exp_pixel(input int idx);
`ifdef DVP_TX_PATTERN_EN
    logic [4:0] r;
    logic [5:0] c;
    r = 5'(idx / 4);
    c = 6'(idx % 4);
    return {r, c, 5'd0};
`else
    return src_tbl[idx % 8];
`endif
  endfunction

`ifndef DVP_TX_PATTERN_EN
  int src_k = 0;
  initial begin
    bus.pix_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (bus.pix_req) begin
        bus.pix_data = src_tbl[src_k % 8];
        src_k++;
      end
    end
  end
`else
  initial bus.pix_data = 16'hFFFF;
`endif

  initial begin
    logic [15:0] px;
    int n;
    resetn     = 1'b0;
    bus.enable = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_vsync", bus.vsync, 1);
      chk("rst_href", bus.href, 0);
      chk("rst_pdata", bus.p_data, 0);
      chk("rst_fcount", bus.frame_count, 0);
      chk("rst_pclock", bus.p_clock, 0);
      chk("rst_fstart", bus.frame_start, 0);
    end
    resetn = 1'b1;

    @(negedge clk);
    chk("rel1_pclock", bus.p_clock, 1);
    chk("rel1_fstart", bus.frame_start, 0);
    @(negedge clk);
    chk("rel2_pclock", bus.p_clock, 0);
    chk("rel2_fstart", bus.frame_start, 1);

    measure(110);
    chk("f1_href_clk", href_clk, 32);
    chk("f1_vsync_clk", vs_clk, 22);
    chk("f1_href_bursts", href_rise, 2);
`ifdef DVP_TX_PATTERN_EN
    chk("f1_pix_req", req_cnt, 0);
`else
    chk("f1_pix_req", req_cnt, 8);
`endif
    chk("f1_fstart_cnt", fs_cnt, 1);
    chk("f1_pdata_idle", bad_pdata, 0);
    chk("f1_nbytes", nrec, 16);
    for (int j = 0; j < 8; j++) begin
      px = exp_pixel(j);
      chk($sformatf("f1_byte_hi%0d", j), rec[2*j], px[15:8]);
      chk($sformatf("f1_byte_lo%0d", j), rec[2*j+1], px[7:0]);
    end
    chk("f2_fstart", bus.frame_start, 1);
    chk("f2_fcount", bus.frame_count, 1);

    step(50);
    chk("drop_href", bus.href, 1);
    bus.enable = 1'b0;
    measure(60);
    chk("drop_href_clk", href_clk, 26);
    chk("drop_href_bursts", href_rise, 1);
    chk("drop_fstart_end", bus.frame_start, 0);
    chk("drop_fcount", bus.frame_count, 2);
    chk("drop_vsync", bus.vsync, 1);
    measure(40);
    chk("idle_fstart_cnt", fs_cnt, 0);
    chk("idle_vsync_clk", vs_clk, 40);
    chk("idle_href_clk", href_clk, 0);
    chk("idle_fcount", bus.frame_count, 2);

    bus.enable = 1'b1;
    n = 0;
    while (n < 4 && !bus.frame_start) begin
      @(negedge clk);
      n++;
    end
    chk("reen_latency", n, 2);

    step(254*110 - 1);
    chk("wrap_fcount_255", bus.frame_count, 8'd255);
    step(1);
    chk("wrap_fcount_0", bus.frame_count, 8'd0);
    chk("wrap_fstart", bus.frame_start, 1);

    step(50);
    chk("mid_href", bus.href, 1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_href", bus.href, 0);
    chk("mid_rst_vsync", bus.vsync, 1);
    chk("mid_rst_pdata", bus.p_data, 0);
    chk("mid_rst_pclock", bus.p_clock, 0);
    @(negedge clk);
    chk("mid_rst_fstart", bus.frame_start, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
